// File: rtl/router_pkg.sv
// router_pkg: shared types and header layout for the multi-port packet router.
package router_pkg;

  typedef enum logic [3:0] {
    ERR_NONE  = 4'd0,
    ERR_PROTO = 4'd1,
    ERR_CRC   = 4'd2,
    ERR_SHORT = 4'd3,
    ERR_LONG  = 4'd4,
    ERR_LEN   = 4'd5,
    ERR_DEST  = 4'd6
  } err_e;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    SEND
  } state_e;

  // Byte offsets of the header fields inside a packet.
  localparam int OFF_DA      = 1;
  localparam int OFF_LEN     = 2;
  localparam int OFF_CRC     = 6;
  localparam int OFF_PAYLOAD = 10;

  // Received-byte counter saturates here so oversized bursts cannot wrap.
  localparam logic [15:0] BYTE_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/router_pkt_buf.sv
// router_pkt_buf: packet store, synchronous write and asynchronous read so the
// forwarding side can present the addressed byte in the same cycle.
module router_pkt_buf #(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write one byte per clock while a packet is being collected.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_mport.sv
// router_mport: collects one byte-serial packet, validates length, size,
// payload checksum and destination, then forwards it to the port named by DA.
module router_mport
  import router_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int MIN_PKT_LEN = 12,
  parameter int MAX_PKT_LEN = 2000,
  parameter int BUF_DEPTH   = 2048,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             dut_inp,
  input  logic                   inp_valid,
  output logic [8*NUM_PORTS-1:0] dut_outp,
  output logic [NUM_PORTS-1:0]   outp_valid,
  input  logic [NUM_PORTS-1:0]   outp_ready,
  output logic                   busy,
  output logic [3:0]             error,
  output logic [CNT_W-1:0]       pkt_in_cnt,
  output logic [CNT_W-1:0]       pkt_out_cnt,
  output logic [CNT_W-1:0]       pkt_drop_cnt
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [15:0] MIN_L = 16'(MIN_PKT_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_PKT_LEN);
  localparam logic [15:0] PAY_L = 16'(OFF_PAYLOAD);

  if (BUF_DEPTH < MAX_PKT_LEN) begin : g_bad_depth
    $error("router_mport: BUF_DEPTH must be >= MAX_PKT_LEN");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > 16) begin : g_bad_ports
    $error("router_mport: NUM_PORTS must be in 1..16");
  end

  state_e        state;
  err_e          err_r;
  err_e          chk_err;
  logic [15:0]   byte_cnt;
  logic [15:0]   rd_ptr;
  logic [31:0]   len_field;
  logic [31:0]   crc_field;
  logic [31:0]   sum;
  logic [7:0]    da;
  logic [PW-1:0] port;
  logic          ignore_burst;
  logic          accept;
  logic          viol;
  logic          check_fail;
  logic          in_range;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [7:0]    buf_rdata;

  assign error      = err_r;
  assign accept     = (state == IDLE) && inp_valid && !ignore_burst;
  assign viol       = busy && inp_valid && !ignore_burst;
  assign check_fail = (state == CHECK) && (chk_err != ERR_NONE);
  assign in_range   = {16'b0, byte_cnt} < 32'(BUF_DEPTH);

  // Validation rules in priority order; the first one that fails names the error.
  always_comb begin
    chk_err = ERR_NONE;
    if ({16'b0, byte_cnt} != len_field)          chk_err = ERR_LEN;
    else if (byte_cnt < MIN_L)                   chk_err = ERR_SHORT;
    else if (byte_cnt > MAX_L)                   chk_err = ERR_LONG;
    else if (sum != crc_field)                   chk_err = ERR_CRC;
    else if ({24'b0, da} >= 32'(NUM_PORTS))      chk_err = ERR_DEST;
  end

  // Buffer write port: byte0 on acceptance, later bytes while in range.
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = '0;
    if (accept) begin
      buf_we = 1'b1;
    end else if (state == RECV && inp_valid && in_range) begin
      buf_we    = 1'b1;
      buf_waddr = byte_cnt[AW-1:0];
    end
  end

  router_pkt_buf #(
    .DEPTH (BUF_DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (dut_inp),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (buf_rdata)
  );

  // Only the selected port sees valid data while forwarding; all else is 0.
  always_comb begin
    dut_outp   = '0;
    outp_valid = '0;
    if (state == SEND) begin
      outp_valid[port]               = 1'b1;
      dut_outp[{port, 3'b000} +: 8]  = buf_rdata;
    end
  end

  // Receive, check and forward sequencing plus error and statistics bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      err_r        <= ERR_NONE;
      byte_cnt     <= '0;
      rd_ptr       <= '0;
      len_field    <= '0;
      crc_field    <= '0;
      sum          <= '0;
      da           <= '0;
      port         <= '0;
      busy         <= 1'b0;
      ignore_burst <= 1'b0;
      pkt_in_cnt   <= '0;
      pkt_out_cnt  <= '0;
      pkt_drop_cnt <= '0;
    end else begin
      ignore_burst <= inp_valid & (ignore_burst | busy);
      pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(check_fail) + CNT_W'(viol);
      case (state)
        IDLE: begin
          if (accept) begin
            byte_cnt  <= 16'd1;
            len_field <= '0;
            crc_field <= '0;
            sum       <= '0;
            da        <= '0;
            err_r     <= ERR_NONE;
            state     <= RECV;
          end
        end
        RECV: begin
          if (inp_valid) begin
            if (byte_cnt != BYTE_CNT_MAX) byte_cnt <= byte_cnt + 16'd1;
            case (byte_cnt)
              16'(OFF_DA):      da               <= dut_inp;
              16'(OFF_LEN):     len_field[7:0]   <= dut_inp;
              16'(OFF_LEN + 1): len_field[15:8]  <= dut_inp;
              16'(OFF_LEN + 2): len_field[23:16] <= dut_inp;
              16'(OFF_LEN + 3): len_field[31:24] <= dut_inp;
              16'(OFF_CRC):     crc_field[7:0]   <= dut_inp;
              16'(OFF_CRC + 1): crc_field[15:8]  <= dut_inp;
              16'(OFF_CRC + 2): crc_field[23:16] <= dut_inp;
              16'(OFF_CRC + 3): crc_field[31:24] <= dut_inp;
              default: ;
            endcase
            if (byte_cnt >= PAY_L) sum <= sum + {24'b0, dut_inp};
          end else begin
            busy       <= 1'b1;
            pkt_in_cnt <= pkt_in_cnt + 1'b1;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (chk_err != ERR_NONE) begin
            err_r <= chk_err;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            port   <= da[PW-1:0];
            rd_ptr <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (outp_ready[port]) begin
            if (rd_ptr == byte_cnt - 16'd1) begin
              busy        <= 1'b0;
              pkt_out_cnt <= pkt_out_cnt + 1'b1;
              state       <= IDLE;
            end else begin
              rd_ptr <= rd_ptr + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (viol) err_r <= ERR_PROTO;
    end
  end

endmodule

// File: tb/tb_router_mport.sv
// tb_router_mport: directed checks of routing, validation errors, backpressure,
// protocol violations and asynchronous reset for router_mport.
module tb_router_mport;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  dut_inp;
  logic        inp_valid;
  logic [31:0] dut_outp;
  logic [3:0]  outp_valid;
  logic [3:0]  outp_ready;
  logic        busy;
  logic [3:0]  error;
  logic [31:0] pkt_in_cnt;
  logic [31:0] pkt_out_cnt;
  logic [31:0] pkt_drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] pkt [0:2047];
  int         pkt_n;
  int         fall_cyc;

  logic [7:0] rx_q [$];
  int         valid_cnt [4];
  int         first_valid;
  int         last_valid;
  int         busy_cycles;
  int         stab_viol;
  logic       prev_valid [4];
  logic       prev_ready [4];
  logic [7:0] prev_data [4];
  logic       toggle_en = 1'b0;

  router_mport #(
    .NUM_PORTS   (4),
    .MIN_PKT_LEN (12),
    .MAX_PKT_LEN (2000),
    .BUF_DEPTH   (2048),
    .CNT_W       (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dut_inp      (dut_inp),
    .inp_valid    (inp_valid),
    .dut_outp     (dut_outp),
    .outp_valid   (outp_valid),
    .outp_ready   (outp_ready),
    .busy         (busy),
    .error        (error),
    .pkt_in_cnt   (pkt_in_cnt),
    .pkt_out_cnt  (pkt_out_cnt),
    .pkt_drop_cnt (pkt_drop_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observe the outputs mid-cycle: record transfers, valid activity and stalls.
  initial forever begin
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      if (outp_valid[p]) begin
        valid_cnt[p]++;
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
      end
      if (outp_valid[p] && outp_ready[p]) rx_q.push_back(dut_outp[8*p +: 8]);
      if (prev_valid[p] && !prev_ready[p] &&
          (!outp_valid[p] || dut_outp[8*p +: 8] !== prev_data[p])) stab_viol++;
      prev_valid[p] = outp_valid[p];
      prev_ready[p] = outp_ready[p];
      prev_data[p]  = dut_outp[8*p +: 8];
    end
    if (busy) busy_cycles++;
  end

  // Toggle port 1 ready every cycle when backpressure is being exercised.
  initial forever begin
    @(posedge clk);
    if (toggle_en) begin
      #1;
      outp_ready[1] = ~outp_ready[1];
    end
  end

  task automatic clear_mon();
    rx_q.delete();
    for (int p = 0; p < 4; p++) begin
      valid_cnt[p]  = 0;
      prev_valid[p] = 1'b0;
      prev_ready[p] = 1'b1;
      prev_data[p]  = 8'h00;
    end
    first_valid = -1;
    last_valid  = -1;
    busy_cycles = 0;
    stab_viol   = 0;
  endtask

  task automatic reset_dut();
    reset      = 1'b1;
    inp_valid  = 1'b0;
    dut_inp    = 8'h00;
    outp_ready = 4'hF;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic build_pkt(input int n, input int len_f, input int da, input int crc_delta);
    logic [31:0] s;
    logic [31:0] crc;
    pkt_n  = n;
    pkt[0] = 8'h5A;
    pkt[1] = 8'(da);
    pkt[2] = 8'(len_f);
    pkt[3] = 8'(len_f >> 8);
    pkt[4] = 8'(len_f >> 16);
    pkt[5] = 8'(len_f >> 24);
    s = 32'd0;
    for (int i = 10; i < n; i++) begin
      pkt[i] = 8'(i * 37 + 11);
      s      = s + {24'b0, pkt[i]};
    end
    crc    = s + 32'(crc_delta);
    pkt[6] = crc[7:0];
    pkt[7] = crc[15:8];
    pkt[8] = crc[23:16];
    pkt[9] = crc[31:24];
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < pkt_n; i++) begin
      @(posedge clk);
      #1;
      inp_valid = 1'b1;
      dut_inp   = pkt[i];
    end
    @(posedge clk);
    #1;
    inp_valid = 1'b0;
    dut_inp   = 8'h00;
    fall_cyc  = cyc;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    inp_valid  = 1'b0;
    dut_inp    = 8'h00;
    outp_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (outp_valid !== 4'h0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", outp_valid); end
    checks++; if (dut_outp !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", dut_outp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (error !== 4'd0) begin errors++; $display("[TB] FAIL reset_error: got %0d expected 0", error); end
    checks++; if (pkt_in_cnt !== 32'd0 || pkt_out_cnt !== 32'd0 || pkt_drop_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_counters: got %0d/%0d/%0d expected 0/0/0", pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || outp_valid !== 4'h0) begin
      errors++; $display("[TB] FAIL post_reset_idle: got busy=%0b valid=%0h expected 0/0", busy, outp_valid);
    end
  endtask

  task automatic test_valid_packet();
    reset_dut();
    clear_mon();
    build_pkt(12, 12, 2, 0);
    pkt[10] = 8'h05; pkt[11] = 8'h07;
    pkt[6] = 8'd12; pkt[7] = 8'd0; pkt[8] = 8'd0; pkt[9] = 8'd0;
    applyStimulus();
    repeat (20) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 12) begin errors++; $display("[TB] FAIL valid_size: got %0d expected 12", rx_q.size()); end
    for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== pkt[i]) begin errors++; $display("[TB] FAIL valid_byte%0d: got %0h expected %0h", i, rx_q[i], pkt[i]); end
    end
    checks++; if (first_valid - fall_cyc != 2) begin errors++; $display("[TB] FAIL valid_latency: got %0d expected 2", first_valid - fall_cyc); end
    checks++; if (last_valid - first_valid != 11 || valid_cnt[2] != 12) begin
      errors++; $display("[TB] FAIL valid_burst: got span %0d cnt %0d expected 11/12", last_valid - first_valid, valid_cnt[2]);
    end
    checks++; if (valid_cnt[0] + valid_cnt[1] + valid_cnt[3] != 0) begin
      errors++; $display("[TB] FAIL valid_other_ports: got %0d expected 0", valid_cnt[0] + valid_cnt[1] + valid_cnt[3]);
    end
    checks++; if (error !== 4'd0) begin errors++; $display("[TB] FAIL valid_error: got %0d expected 0", error); end
    checks++; if (pkt_in_cnt !== 32'd1 || pkt_out_cnt !== 32'd1 || pkt_drop_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL valid_counters: got %0d/%0d/%0d expected 1/1/0", pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt);
    end
    checks++; if (busy_cycles != 13) begin errors++; $display("[TB] FAIL valid_busy_cycles: got %0d expected 13", busy_cycles); end
  endtask

  task automatic test_crc_error();
    reset_dut();
    clear_mon();
    build_pkt(12, 12, 2, 0);
    pkt[10] = 8'h05; pkt[11] = 8'h07;
    pkt[6] = 8'd13; pkt[7] = 8'd0; pkt[8] = 8'd0; pkt[9] = 8'd0;
    applyStimulus();
    repeat (6) @(posedge clk);
    #1;
    checks++; if (error !== 4'd2) begin errors++; $display("[TB] FAIL crc_error: got %0d expected 2", error); end
    checks++; if (pkt_drop_cnt !== 32'd1 || pkt_out_cnt !== 32'd0 || pkt_in_cnt !== 32'd1) begin
      errors++; $display("[TB] FAIL crc_counters: got %0d/%0d/%0d expected in1/out0/drop1", pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt);
    end
    checks++; if (first_valid != -1) begin errors++; $display("[TB] FAIL crc_no_output: got first valid at %0d expected none", first_valid); end
    checks++; if (busy_cycles != 1) begin errors++; $display("[TB] FAIL crc_busy_cycles: got %0d expected 1", busy_cycles); end
  endtask

  task automatic test_len_errors();
    reset_dut();
    clear_mon();
    build_pkt(15, 20, 1, 0);
    applyStimulus();
    repeat (5) @(posedge clk);
    #1;
    checks++; if (error !== 4'd5) begin errors++; $display("[TB] FAIL len_mismatch: got %0d expected 5", error); end
    build_pkt(8, 8, 1, 0);
    applyStimulus();
    repeat (5) @(posedge clk);
    #1;
    checks++; if (error !== 4'd3) begin errors++; $display("[TB] FAIL len_short: got %0d expected 3", error); end
    build_pkt(2001, 2001, 1, 0);
    applyStimulus();
    repeat (5) @(posedge clk);
    #1;
    checks++; if (error !== 4'd4) begin errors++; $display("[TB] FAIL len_long: got %0d expected 4", error); end
    build_pkt(12, 12, 7, 0);
    applyStimulus();
    repeat (5) @(posedge clk);
    #1;
    checks++; if (error !== 4'd6) begin errors++; $display("[TB] FAIL bad_dest: got %0d expected 6", error); end
    checks++; if (pkt_in_cnt !== 32'd4 || pkt_drop_cnt !== 32'd4 || pkt_out_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL len_counters: got %0d/%0d/%0d expected in4/out0/drop4", pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt);
    end
    checks++; if (first_valid != -1) begin errors++; $display("[TB] FAIL len_no_output: got first valid at %0d expected none", first_valid); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    clear_mon();
    build_pkt(100, 100, 1, 0);
    applyStimulus();
    toggle_en = 1'b1;
    repeat (260) @(posedge clk);
    toggle_en = 1'b0;
    #2;
    outp_ready = 4'hF;
    checks++; if (rx_q.size() != 100) begin errors++; $display("[TB] FAIL bp_size: got %0d expected 100", rx_q.size()); end
    for (int i = 0; i < 100 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== pkt[i]) begin errors++; $display("[TB] FAIL bp_byte%0d: got %0h expected %0h", i, rx_q[i], pkt[i]); end
    end
    checks++; if (stab_viol != 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d unstable stalls expected 0", stab_viol); end
    checks++; if (valid_cnt[1] < 199 || valid_cnt[1] > 200) begin
      errors++; $display("[TB] FAIL bp_valid_cycles: got %0d expected 199..200", valid_cnt[1]);
    end
    checks++; if (valid_cnt[0] + valid_cnt[2] + valid_cnt[3] != 0) begin
      errors++; $display("[TB] FAIL bp_other_ports: got %0d expected 0", valid_cnt[0] + valid_cnt[2] + valid_cnt[3]);
    end
    checks++; if (pkt_out_cnt !== 32'd1 || error !== 4'd0) begin
      errors++; $display("[TB] FAIL bp_done: got out=%0d err=%0d expected 1/0", pkt_out_cnt, error);
    end
  endtask

  task automatic test_proto_violation();
    reset_dut();
    clear_mon();
    build_pkt(30, 30, 0, 0);
    applyStimulus();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      inp_valid = 1'b1;
      dut_inp   = 8'hEE;
      @(posedge clk);
      #1;
    end
    inp_valid = 1'b0;
    dut_inp   = 8'h00;
    checks++; if (error !== 4'd1) begin errors++; $display("[TB] FAIL proto_error: got %0d expected 1", error); end
    checks++; if (pkt_drop_cnt !== 32'd1) begin errors++; $display("[TB] FAIL proto_drop: got %0d expected 1", pkt_drop_cnt); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 30 || valid_cnt[0] != 30) begin
      errors++; $display("[TB] FAIL proto_fwd_size: got %0d bytes %0d valid expected 30/30", rx_q.size(), valid_cnt[0]);
    end
    for (int i = 0; i < 30 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== pkt[i]) begin errors++; $display("[TB] FAIL proto_byte%0d: got %0h expected %0h", i, rx_q[i], pkt[i]); end
    end
    checks++; if (pkt_in_cnt !== 32'd1 || pkt_out_cnt !== 32'd1 || error !== 4'd1) begin
      errors++; $display("[TB] FAIL proto_after_send: got in=%0d out=%0d err=%0d expected 1/1/1", pkt_in_cnt, pkt_out_cnt, error);
    end
    clear_mon();
    build_pkt(12, 12, 3, 0);
    applyStimulus();
    repeat (20) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 12 || valid_cnt[3] != 12) begin
      errors++; $display("[TB] FAIL proto_next_size: got %0d bytes %0d valid expected 12/12", rx_q.size(), valid_cnt[3]);
    end
    checks++; if (error !== 4'd0) begin errors++; $display("[TB] FAIL proto_next_error: got %0d expected 0", error); end
    checks++; if (pkt_in_cnt !== 32'd2 || pkt_out_cnt !== 32'd2 || pkt_drop_cnt !== 32'd1) begin
      errors++; $display("[TB] FAIL proto_next_counters: got %0d/%0d/%0d expected 2/2/1", pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt);
    end
  endtask

  task automatic test_reset_mid_send();
    reset_dut();
    clear_mon();
    build_pkt(50, 50, 3, 0);
    applyStimulus();
    repeat (12) @(posedge clk);
    #1;
    checks++; if (outp_valid !== 4'b1000) begin errors++; $display("[TB] FAIL midsend_active: got %0h expected 8", outp_valid); end
    reset = 1'b1;
    #1;
    checks++; if (outp_valid !== 4'h0 || dut_outp !== 32'h0) begin
      errors++; $display("[TB] FAIL midsend_outputs: got valid=%0h data=%0h expected 0/0", outp_valid, dut_outp);
    end
    checks++; if (busy !== 1'b0 || error !== 4'd0) begin
      errors++; $display("[TB] FAIL midsend_status: got busy=%0b err=%0d expected 0/0", busy, error);
    end
    checks++; if (pkt_in_cnt !== 32'd0 || pkt_out_cnt !== 32'd0 || pkt_drop_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL midsend_counters: got %0d/%0d/%0d expected 0/0/0", pkt_in_cnt, pkt_out_cnt, pkt_drop_cnt);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_mon();
    build_pkt(12, 12, 3, 0);
    applyStimulus();
    repeat (20) @(posedge clk);
    #1;
    checks++; if (rx_q.size() != 12) begin errors++; $display("[TB] FAIL after_reset_size: got %0d expected 12", rx_q.size()); end
    for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== pkt[i]) begin errors++; $display("[TB] FAIL after_reset_byte%0d: got %0h expected %0h", i, rx_q[i], pkt[i]); end
    end
    checks++; if (pkt_in_cnt !== 32'd1 || pkt_out_cnt !== 32'd1 || error !== 4'd0) begin
      errors++; $display("[TB] FAIL after_reset_counters: got in=%0d out=%0d err=%0d expected 1/1/0", pkt_in_cnt, pkt_out_cnt, error);
    end
  endtask

  initial begin
    reset      = 1'b1;
    inp_valid  = 1'b0;
    dut_inp    = 8'h00;
    outp_ready = 4'hF;
    clear_mon();
    $display("[TB] starting router_mport tests");
    test_reset();
    test_valid_packet();
    test_crc_error();
    test_len_errors();
    test_backpressure();
    test_proto_violation();
    test_reset_mid_send();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_mport.md
Name: router_mport

Overview:
Store-and-forward packet router, parametrised successor of the single-port router. Collects one byte-serial packet, checks length field, size limits, payload checksum and destination, then forwards it to one of NUM_PORTS outputs selected by the DA byte, with per-port ready backpressure. Synthesizable: fixed buffer, explicit FSM, no queues or unbounded loops. Sits between the packet generator/driver interface and per-port sinks.

Parameters:
NUM_PORTS, 4, number of output ports (1..16); port index = DA byte.
MIN_PKT_LEN, 12, minimum legal packet length in bytes.
MAX_PKT_LEN, 2000, maximum legal packet length in bytes.
BUF_DEPTH, 2048, packet buffer bytes; must be >= MAX_PKT_LEN (elaboration check).
CNT_W, 32, statistics counter width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
dut_inp  in  8  input byte
inp_valid  in  1  high for every byte of a packet, contiguous; low between packets
dut_outp  out  8*NUM_PORTS  per-port output byte, port p at [8p+7:8p]
outp_valid  out  NUM_PORTS  per-port byte valid
outp_ready  in  NUM_PORTS  per-port sink ready
busy  out  1  high while checking or forwarding
error  out  4  last error code (package enum)
pkt_in_cnt  out  CNT_W  packets received
pkt_out_cnt  out  CNT_W  packets fully forwarded
pkt_drop_cnt  out  CNT_W  packets dropped

Behaviour:
- Packet: byte0 SA, byte1 DA, bytes2-5 length (byte2 = LSB), bytes6-9 CRC (byte6 = LSB), bytes10.. payload. CRC = 32-bit modulo sum of payload bytes.
- Reset: all outputs 0 (dut_outp 0, outp_valid 0, busy 0, error 0, counters 0); FSM IDLE; any buffered packet discarded. Reset mid-receive or mid-send aborts immediately; no partial counting.
- FSM IDLE: inp_valid=1 at an edge -> store byte0, byte_cnt=1, error<=0, -> RECV.
- RECV: each edge with inp_valid=1 stores byte at byte_cnt (write suppressed if byte_cnt >= BUF_DEPTH; counting continues, saturating at 2^16-1); capture length bytes 2-5 and CRC bytes 6-9 into registers; add bytes index >= 10 into running sum. First edge with inp_valid=0 -> CHECK, pkt_in_cnt++.
- CHECK (one cycle, busy=1), first failing rule wins:
  byte_cnt != length field -> error 5;
  byte_cnt < MIN_PKT_LEN -> error 3;
  byte_cnt > MAX_PKT_LEN -> error 4;
  sum != CRC -> error 2;
  DA >= NUM_PORTS -> error 6.
  Fail -> pkt_drop_cnt++, busy<=0, -> IDLE. Pass -> latch port=DA, rd_ptr=0, -> SEND.
- SEND: outp_valid[port]=1, dut_outp[port]=buf[rd_ptr]; all other ports valid 0, data 0. Byte transfers on an edge with outp_valid & outp_ready; data/valid held stable while ready=0. After last byte transfers: outp_valid 0, dut_outp 0, busy 0, pkt_out_cnt++, -> IDLE at same edge.
- Latency: edge that samples first inp_valid=0 enters CHECK; next edge asserts outp_valid with byte0 (ready held high -> one byte per cycle, N-byte packet completes N cycles later).
- Protocol violation: inp_valid=1 while busy=1 -> error<=1, whole burst ignored (stays ignored until inp_valid=0, even if forwarding ends mid-burst); forwarding of current packet unaffected; pkt_drop_cnt++ once per burst.
- New packet accepted in IDLE on the edge after SEND completes; back-to-back input requires a >=1 cycle inp_valid gap.
- error holds its value until cleared at start of next accepted packet. Counters wrap at 2^CNT_W.

Decomposition:
- router_pkg: err_e (ERR_NONE=0, ERR_PROTO=1, ERR_CRC=2, ERR_SHORT=3, ERR_LONG=4, ERR_LEN=5, ERR_DEST=6); state_e (IDLE, RECV, CHECK, SEND); header offset constants (OFF_DA=1, OFF_LEN=2, OFF_CRC=6, OFF_PAYLOAD=10).
- Sub-module router_pkt_buf: BUF_DEPTH x 8 single-write/single-read RAM, sync write, async read (so SEND presents data in cycle), address width $clog2(BUF_DEPTH).

Test Plan:
- Valid 12-byte packet, DA=2, payload 0x05,0x07, CRC=12, len=12, ready high -> outp_valid[2] 12 consecutive cycles starting 2 edges after inp_valid falls, bytes identical, error 0, pkt_out_cnt=1.
- Same packet with CRC=13 -> no outp_valid, error=2, pkt_drop_cnt=1, busy never exceeds 1 cycle.
- Length field 20 but 15 bytes sent -> error 5; 8-byte packet with len=8 -> error 3; 2001-byte packet with len=2001 -> error 4; DA=7 with NUM_PORTS=4 -> error 6.
- 100-byte packet to port 1, outp_ready[1] toggled 0/1 every cycle -> 100 bytes delivered over ~200 cycles, data stable while ready low, other ports idle.
- inp_valid pulsed during SEND -> error=1, forwarded packet intact, following legal packet accepted and error cleared to 0.
- Reset asserted mid-SEND of a 50-byte packet -> outputs 0 immediately, counters 0, next packet routes normally.
